uart_baud_gen: RTL and testbench

Parametrised, runtime-programmable successor to the fixed-ratio clock divider, used as the UART baud source. It divides clk_in by a loadable divisor and produces three outputs: a single-cycle oversample tick for the RX sampler, a single-cycle bit tick for TX, and a 50%-duty bit-rate clock for observation. It supports glitch-free divisor changes at bit boundaries, an enable/stall input, and a phase resync for RX start-bit alignment.

---
 rtl/uart_baud_gen.sv | 146 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable UART baud source.
// Divides clk_in by a loadable divisor to make an oversample tick, a bit tick
// and a 50%-duty bit-rate clock. Divisor changes take effect at bit boundaries.
// Ports:
//   clk_in      system clock, rising edge
//   reset       synchronous active-high reset, highest priority
//   enable      1 = counters run, 0 = counters hold
//   resync      single-cycle request to restart the bit phase
//   div_value   new divisor (clk_in cycles per rx_tick)
//   div_load    single-cycle strobe capturing div_value
//   div_pending captured divisor waiting for the next bit boundary
//   rx_tick     one-cycle pulse, OVERSAMPLE per bit
//   tx_tick     one-cycle pulse, one per bit
//   clk_out     bit-rate square wave, low first half / high second half
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 resync,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 div_pending,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic                 clk_out
);

  // OVERSAMPLE is expected to be even and at least 2.
  localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]      OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST    = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic                 pending_q, pending_d;
  logic                 rx_q, rx_d;
  logic                 tx_q, tx_d;
  logic                 clk_q, clk_d;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 div_wrap;
  logic                 os_wrap;

  // Divisor 0 behaves as 1; >= keeps the prescaler sane if the divisor
  // shrinks below the held count while stopped.
  assign div_eff  = (div_act_q == '0) ? DIV_ONE : div_act_q;
  assign div_wrap = (div_cnt_q >= (div_eff - DIV_ONE));
  assign os_wrap  = (os_cnt_q == OS_LAST);

  // Next-state logic for prescaler, oversample counter, outputs and divisor.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    os_cnt_d     = os_cnt_q;
    div_act_d    = div_act_q;
    div_shadow_d = div_shadow_q;
    pending_d    = pending_q;
    clk_d        = clk_q;
    rx_d         = 1'b0;
    tx_d         = 1'b0;

    if (resync) begin
      // Restart the bit phase; any divisor change lands immediately.
      div_cnt_d = '0;
      os_cnt_d  = '0;
      clk_d     = 1'b0;
      pending_d = 1'b0;
      if (div_load) begin
        div_act_d    = div_value;
        div_shadow_d = div_value;
      end else if (pending_q) begin
        div_act_d = div_shadow_q;
      end
    end else if (!enable) begin
      // Stopped: phase holds, a new divisor cannot disturb a running bit.
      if (div_load) begin
        div_act_d    = div_value;
        div_shadow_d = div_value;
        pending_d    = 1'b0;
      end
    end else begin
      if (div_wrap) begin
        div_cnt_d = '0;
        rx_d      = 1'b1;
        if (os_wrap) begin
          // Bit boundary: tx tick, clk_out low, swap in the shadow divisor.
          os_cnt_d = '0;
          tx_d     = 1'b1;
          clk_d    = 1'b0;
          if (pending_q) begin
            div_act_d = div_shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_MID_PRE) begin
            clk_d = 1'b1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
      // A load on the boundary edge waits for the following bit.
      if (div_load) begin
        div_shadow_d = div_value;
        pending_d    = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      div_act_q    <= DIV_RST;
      div_shadow_q <= '0;
      pending_q    <= 1'b0;
      rx_q         <= 1'b0;
      tx_q         <= 1'b0;
      clk_q        <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      div_act_q    <= div_act_d;
      div_shadow_q <= div_shadow_d;
      pending_q    <= pending_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      clk_q        <= clk_d;
    end
  end

  assign div_pending = pending_q;
  assign rx_tick     = rx_q;
  assign tx_tick     = tx_q;
  assign clk_out     = clk_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus pushes expected tick/edge
// cycles and level checks; a negedge monitor pops and compares.
module tb_uart_baud_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned OS = 16;
  localparam int unsigned BIG = 32'hFFFF_FFFF;

  // Signal selectors for level checks.
  localparam int unsigned S_PEND = 0;
  localparam int unsigned S_CLK  = 1;
  localparam int unsigned S_RX   = 2;
  localparam int unsigned S_TX   = 3;

  typedef struct {
    int unsigned cyc;
    int unsigned sig;
    int unsigned val;
  } lvl_t;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          resync;
  logic [DW-1:0] div_value;
  logic          div_load;
  logic          div_pending;
  logic          rx_tick;
  logic          tx_tick;
  logic          clk_out;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic        clk_prev = 1'b0;

  int unsigned rx_q[$];
  int unsigned tx_q[$];
  int unsigned ck_q[$];
  lvl_t        lv_q[$];

  uart_baud_gen #(.DIV_WIDTH(DW), .OVERSAMPLE(OS), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .resync      (resync),
    .div_value   (div_value),
    .div_load    (div_load),
    .div_pending (div_pending),
    .rx_tick     (rx_tick),
    .tx_tick     (tx_tick),
    .clk_out     (clk_out)
  );

  always #5 clk_in = ~clk_in;

  // Posedge count; an output registered on edge N is sampled at cyc == N.
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic int unsigned adj(input int unsigned e, input int unsigned gs,
                                      input int unsigned gl);
    return (gl != 0 && e >= gs) ? e + gl : e;
  endfunction

  // Expected events of one bit whose first enabled edge is s, divisor d;
  // edges from gs on are pushed back by gl stalled edges; events >= cut dropped.
  task automatic push_bit(input int unsigned s, input int unsigned d,
                          input int unsigned gs, input int unsigned gl,
                          input int unsigned cut);
    int unsigned e;
    for (int k = 0; k < OS; k++) begin
      e = adj(s + d - 1 + k * d, gs, gl);
      if (e < cut) rx_q.push_back(e);
    end
    e = adj(s - 1 + (OS / 2) * d, gs, gl);
    if (e < cut) ck_q.push_back(e);
    e = adj(s - 1 + OS * d, gs, gl);
    if (e < cut) begin
      ck_q.push_back(e);
      tx_q.push_back(e);
    end
  endtask

  task automatic expect_lvl(input int unsigned c, input int unsigned sig,
                            input int unsigned val);
    lvl_t l;
    l.cyc = c;
    l.sig = sig;
    l.val = val;
    lv_q.push_back(l);
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) @(negedge clk_in);
  endtask

  task automatic load_div(input int unsigned v);
    div_value = DW'(v);
    div_load  = 1'b1;
    @(negedge clk_in);
    div_load  = 1'b0;
  endtask

  // Monitor: compares DUT activity against the scoreboard queues.
  always @(negedge clk_in) begin
    int unsigned act;
    while (rx_q.size() != 0 && rx_q[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL rx_tick missing: required at cyc=%0d, actual none", rx_q[0]);
      void'(rx_q.pop_front());
    end
    if (rx_tick) begin
      n_chk++;
      if (rx_q.size() != 0 && rx_q[0] == cyc) void'(rx_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL rx_tick unexpected: actual 1 at cyc=%0d, required 0", cyc);
      end
    end

    while (tx_q.size() != 0 && tx_q[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL tx_tick missing: required at cyc=%0d, actual none", tx_q[0]);
      void'(tx_q.pop_front());
    end
    if (tx_tick) begin
      n_chk++;
      if (tx_q.size() != 0 && tx_q[0] == cyc) void'(tx_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL tx_tick unexpected: actual 1 at cyc=%0d, required 0", cyc);
      end
    end

    while (ck_q.size() != 0 && ck_q[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL clk_out edge missing: required at cyc=%0d, actual none", ck_q[0]);
      void'(ck_q.pop_front());
    end
    if (clk_out != clk_prev) begin
      n_chk++;
      if (ck_q.size() != 0 && ck_q[0] == cyc) void'(ck_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL clk_out edge unexpected: actual %0b at cyc=%0d, required %0b",
                 clk_out, cyc, clk_prev);
      end
      clk_prev = clk_out;
    end

    while (lv_q.size() != 0 && lv_q[0].cyc <= cyc) begin
      case (lv_q[0].sig)
        S_PEND:  act = 32'(div_pending);
        S_CLK:   act = 32'(clk_out);
        S_RX:    act = 32'(rx_tick);
        default: act = 32'(tx_tick);
      endcase
      n_chk++;
      if (lv_q[0].cyc != cyc || act != lv_q[0].val) begin
        n_fail++;
        $display("FAIL level sig%0d at cyc=%0d (due %0d): actual %0d, required %0d",
                 lv_q[0].sig, cyc, lv_q[0].cyc, act, lv_q[0].val);
      end
      void'(lv_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s, s2, s3, b4, b5, r, b6;
    reset     = 1'b1;
    enable    = 1'b0;
    resync    = 1'b0;
    div_value = '0;
    div_load  = 1'b0;

    // Reset state.
    expect_lvl(2, S_PEND, 0);
    expect_lvl(2, S_CLK, 0);
    expect_lvl(2, S_RX, 0);
    expect_lvl(2, S_TX, 0);
    repeat (2) @(negedge clk_in);

    // 1: default divisor 4, two bits.
    reset  = 1'b0;
    enable = 1'b1;
    s = cyc + 1;
    push_bit(s, 4, 0, 0, BIG);
    push_bit(s + 64, 4, 0, 0, BIG);
    run_to(s + 127);
    enable = 1'b0;
    @(negedge clk_in);

    // 2: divisor 0 loaded while stopped, then divisor 1.
    expect_lvl(cyc + 1, S_PEND, 0);
    load_div(0);
    enable = 1'b1;
    s2 = cyc + 1;
    push_bit(s2, 1, 0, 0, BIG);
    push_bit(s2 + 16, 1, 0, 0, BIG);
    run_to(s2 + 31);
    enable = 1'b0;
    @(negedge clk_in);
    expect_lvl(cyc + 1, S_PEND, 0);
    load_div(1);
    enable = 1'b1;
    s2 = cyc + 1;
    push_bit(s2, 1, 0, 0, BIG);
    run_to(s2 + 15);
    enable = 1'b0;
    @(negedge clk_in);

    // 3: back to 4, then load 10 at cycle 20 of a bit.
    load_div(4);
    enable = 1'b1;
    s3 = cyc + 1;
    push_bit(s3, 4, 0, 0, BIG);
    push_bit(s3 + 64, 10, 0, 0, BIG);
    run_to(s3 + 18);
    expect_lvl(s3 + 19, S_PEND, 1);
    expect_lvl(s3 + 62, S_PEND, 1);
    expect_lvl(s3 + 63, S_PEND, 0);
    load_div(10);

    // 4: 7-cycle stall in the high half of a D=10 bit.
    b4 = s3 + 224;
    push_bit(b4, 10, b4 + 100, 7, BIG);
    run_to(b4 + 99);
    enable = 1'b0;
    expect_lvl(b4 + 103, S_CLK, 1);
    expect_lvl(b4 + 104, S_RX, 0);
    run_to(b4 + 106);
    enable = 1'b1;

    // 5: pending 6, resync while clk_out is high.
    b5 = b4 + 167;
    r  = b5 + 123;
    push_bit(b5, 10, 0, 0, r);
    ck_q.push_back(r);
    push_bit(r + 1, 6, 0, 0, BIG);
    run_to(b5 + 4);
    expect_lvl(b5 + 5, S_PEND, 1);
    load_div(6);
    run_to(r - 1);
    expect_lvl(r, S_PEND, 0);
    expect_lvl(r, S_CLK, 0);
    expect_lvl(r, S_RX, 0);
    resync = 1'b1;
    @(negedge clk_in);
    resync = 1'b0;

    // 6: reset mid-bit with pending 10; default divisor returns.
    b6 = r + 97;
    push_bit(b6, 6, 0, 0, b6 + 20);
    push_bit(b6 + 21, 4, 0, 0, BIG);
    push_bit(b6 + 85, 4, 0, 0, BIG);
    run_to(b6 + 2);
    expect_lvl(b6 + 3, S_PEND, 1);
    load_div(10);
    run_to(b6 + 19);
    expect_lvl(b6 + 20, S_PEND, 0);
    expect_lvl(b6 + 20, S_CLK, 0);
    expect_lvl(b6 + 20, S_RX, 0);
    expect_lvl(b6 + 20, S_TX, 0);
    expect_lvl(b6 + 84, S_PEND, 0);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    run_to(b6 + 148);
    enable = 1'b0;
    run_to(b6 + 152);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
